aes_round_ctrl: RTL and testbench
=================================

Name: aes_round_ctrl

Overview:
- Sequencing controller for the iterative AES-128 encryption datapath.
- Accepts one 128-bit block per start handshake and steps the round-key multiplexer select from 0 through 10.
- Drives the state-register load/enable and the MixColumns bypass for each round.
- Raises a valid/ready result handshake when the final round completes.
- Sits between the top-level block interface and the round datapath (state register, round function, round-key mux).

Parameters:
- NR, 10, number of AES rounds; key_sel spans 0..NR.
- SEL_W, 4, width of key_sel; 2**SEL_W must exceed NR.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  new plaintext block presented
- in_ready  output  1  controller can accept a block this cycle
- key_ready  input  1  expanded round keys stable and usable
- state_load  output  1  load state register with plaintext XOR round key 0
- state_en  output  1  update state register with round-function output
- mix_en  output  1  1 = apply MixColumns, 0 = bypass (final round)
- key_sel  output  SEL_W  round-key index to the 11:1 key mux
- round_idx  output  SEL_W  current round number, for debug and status
- out_valid  output  1  ciphertext in state register is final
- out_ready  input  1  consumer takes ciphertext

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: FSM = IDLE, round = 0, out_valid = 0, state_load = 0, state_en = 0, mix_en = 0, key_sel = 0, round_idx = 0, in_ready = 1.
- Registers: FSM state and round counter (SEL_W bits). key_sel = round_idx = round in every state. All other outputs are decoded combinationally from FSM state and handshake inputs.
- Accept condition: acc = in_valid & in_ready & key_ready.
- IDLE:
  - in_ready = 1.
  - On acc: state_load = 1 (key_sel = 0); round <= 1; next state RND.
  - Without key_ready: no load, remain IDLE.
- RND (rounds 1..NR-1):
  - state_en = 1, mix_en = 1.
  - round <= round + 1.
  - When round == NR-1, next state FIN (round becomes NR).
- FIN:
  - state_en = 1, mix_en = 0, key_sel = NR.
  - round <= 0; next state DONE.
- DONE:
  - out_valid = 1; out_valid and the datapath hold until out_ready.
  - out_ready without acc: next state IDLE.
  - out_ready with acc (in_ready = out_ready in DONE): back-to-back acceptance; state_load = 1, round <= 1, next state RND. No bubble cycle.
- Latency: acceptance at cycle T; RND occupies T+1..T+NR-1; FIN at T+NR; out_valid first high at T+NR+1 (T+11 for NR = 10).
- Throughput: one block per NR+1 cycles with back-to-back acceptance.
- in_ready = (IDLE) | (DONE & out_ready). in_valid is ignored in RND and FIN.
- key_ready is sampled only at acceptance. The key schedule must stay stable until out_valid & out_ready; a key change mid-block is not detected.
- Invariants:
  - key_sel never exceeds NR, so the mux default (all-zero output) is never selected.
  - state_load and state_en are never both 1.
  - state_en is 1 for exactly NR cycles per block.
- Reset mid-operation: returns to IDLE immediately with all outputs at reset values. The partial block is discarded and no out_valid is produced.
- Unreachable FSM encodings recover to IDLE.

Decomposition:
- Shared package aes_pkg holds:
  - NR_AES128 = 10
  - SEL_W default = 4
  - enum ctrl_state_t {IDLE, RND, FIN, DONE}
  - key_sel_t typedef
- No sub-module is natural. The FSM and round counter are tightly coupled, so the block stays flat (roughly 150 lines).

Test Plan:
- Reset, then a single block: rst_n low 3 cycles; in_valid = 1, key_ready = 1 at T.
  - state_load pulse at T with key_sel = 0.
  - key_sel = 1..9 with mix_en = 1 at T+1..T+9.
  - key_sel = 10 with mix_en = 0 at T+10.
  - out_valid = 1 at T+11.
- Back-pressure: out_ready = 0 for 5 cycles after out_valid.
  - out_valid stays 1; state_en = 0; key_sel = 0; in_ready = 0.
  - Releases to IDLE on the cycle out_ready = 1.
- Back-to-back: in_valid held high and out_ready = 1.
  - Second state_load coincides with the first out_valid & out_ready cycle.
  - Blocks complete every 11 cycles; no gaps.
- key_ready gating: in_valid = 1, key_ready = 0 for 4 cycles.
  - No state_load; FSM stays IDLE.
  - Acceptance occurs on the first cycle key_ready = 1.
- Reset mid-block: assert rst_n at round 5.
  - All outputs zero asynchronously, and in_ready = 1 after release.
  - No out_valid appears for the aborted block.
- Assertions checked throughout: key_sel <= 10; state_en count per block = 10; state_load & state_en never both 1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 iterative datapath controller.
package aes_pkg;

  localparam int NR_AES128 = 10;
  localparam int SEL_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RND  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } ctrl_state_t;

  typedef logic [SEL_W_DEF-1:0] key_sel_t;

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 encryption datapath: loads a
// block, steps the round-key select 0..NR, bypasses MixColumns on the final
// round and holds the ciphertext under a valid/ready result handshake.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR    = NR_AES128,
  parameter int SEL_W = SEL_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             key_ready,
  output logic             state_load,
  output logic             state_en,
  output logic             mix_en,
  output logic [SEL_W-1:0] key_sel,
  output logic [SEL_W-1:0] round_idx,
  output logic             out_valid,
  input  logic             out_ready
);

  // Round on which the FSM leaves RND; the following cycle is the final round.
  localparam logic [SEL_W-1:0] LAST_MIX_RND = SEL_W'(NR - 1);
  localparam logic [SEL_W-1:0] FIRST_RND    = SEL_W'(1);

  ctrl_state_t      state_q, state_d;
  logic [SEL_W-1:0] round_q, round_d;
  logic             acc;

  // Key select and debug round number both follow the round counter directly.
  assign key_sel   = round_q;
  assign round_idx = round_q;

  // Ready in IDLE, or in DONE on the same cycle the result is consumed so a
  // new block can enter without a bubble.
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);

  // key_ready only matters at acceptance; the key schedule is assumed stable
  // for the rest of the block.
  assign acc = in_valid & in_ready & key_ready;

  // Next-state, round-counter and datapath control decode.
  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    state_load = 1'b0;
    state_en   = 1'b0;
    mix_en     = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          state_load = 1'b1;
          round_d    = FIRST_RND;
          state_d    = RND;
        end
      end
      RND: begin
        state_en = 1'b1;
        mix_en   = 1'b1;
        round_d  = round_q + 1'b1;
        if (round_q == LAST_MIX_RND) begin
          state_d = FIN;
        end
      end
      FIN: begin
        // Final round: MixColumns bypassed, key_sel is NR here.
        state_en = 1'b1;
        round_d  = '0;
        state_d  = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (acc) begin
            state_load = 1'b1;
            round_d    = FIRST_RND;
            state_d    = RND;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
  end

  // State and round counter registers; reset discards any block in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed stimulus, a cycle-age
// reference model compared every cycle, and hand-computed spot checks.
module tb_aes_round_ctrl;

  localparam int NR    = 10;
  localparam int SEL_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             key_ready;
  logic             state_load;
  logic             state_en;
  logic             mix_en;
  logic [SEL_W-1:0] key_sel;
  logic [SEL_W-1:0] round_idx;
  logic             out_valid;
  logic             out_ready;

  int total = 0;
  int bad   = 0;

  aes_round_ctrl #(.NR(NR), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .key_ready(key_ready),
    .state_load(state_load), .state_en(state_en), .mix_en(mix_en),
    .key_sel(key_sel), .round_idx(round_idx),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: age = cycles since the block was accepted (-1 = no block).
  // Ages 1..NR are rounds, age > NR means the result waits for out_ready.
  int m_age;

  function automatic bit m_in_ready();
    return (m_age < 0) || (m_age > NR && out_ready);
  endfunction

  function automatic bit m_acc();
    return m_in_ready() && in_valid && key_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          m_age <= -1;
    else if (m_acc())                    m_age <= 1;
    else if (m_age >= 1 && m_age <= NR)  m_age <= m_age + 1;
    else if (m_age > NR && out_ready)    m_age <= -1;
  end

  // Every-cycle comparison against the model plus invariants.
  bit cmp_en = 1'b0;
  int en_cnt = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_in_ready",  int'(in_ready),   int'(m_in_ready()));
      chk("m_state_load", int'(state_load), int'(m_acc()));
      chk("m_state_en",  int'(state_en),   int'(m_age >= 1 && m_age <= NR));
      chk("m_mix_en",    int'(mix_en),     int'(m_age >= 1 && m_age < NR));
      chk("m_key_sel",   int'(key_sel),    (m_age >= 1 && m_age <= NR) ? m_age : 0);
      chk("m_round_idx", int'(round_idx),  (m_age >= 1 && m_age <= NR) ? m_age : 0);
      chk("m_out_valid", int'(out_valid),  int'(m_age > NR));
      if (key_sel > SEL_W'(NR)) chk("inv_key_sel_max", int'(key_sel), NR);
      if (state_load && state_en) chk("inv_load_en_excl", 1, 0);
      if (!rst_n) begin
        en_cnt = 0;
      end else begin
        if (out_valid && out_ready) chk("inv_en_count", en_cnt, NR);
        if (state_load) en_cnt = 0;
        if (state_en) en_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int cyc, last_load, n_loads, n_ov;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; key_ready = 1'b0; out_ready = 1'b0;
    repeat (3) step();
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_state_load", int'(state_load), 0);
    chk("rst_state_en", int'(state_en), 0);
    chk("rst_key_sel", int'(key_sel), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    step();

    // Single block, accepted at T.
    in_valid = 1'b1; key_ready = 1'b1; out_ready = 1'b0;
    #1;
    chk("t0_load", int'(state_load), 1);
    chk("t0_key_sel", int'(key_sel), 0);
    step(); in_valid = 1'b0; #1;
    chk("t1_key_sel", int'(key_sel), 1);
    chk("t1_mix_en", int'(mix_en), 1);
    chk("t1_state_en", int'(state_en), 1);
    repeat (8) step();
    #1;
    chk("t9_key_sel", int'(key_sel), 9);
    chk("t9_mix_en", int'(mix_en), 1);
    step(); #1;
    chk("t10_key_sel", int'(key_sel), 10);
    chk("t10_mix_en", int'(mix_en), 0);
    chk("t10_state_en", int'(state_en), 1);
    step(); #1;
    chk("t11_out_valid", int'(out_valid), 1);
    chk("t11_key_sel", int'(key_sel), 0);

    // Back-pressure for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      step(); #1;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_state_en", int'(state_en), 0);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_in_ready", int'(in_ready), 1);
    step(); #1;
    chk("bp_idle_out_valid", int'(out_valid), 0);
    chk("bp_idle_in_ready", int'(in_ready), 1);

    // Back-to-back blocks.
    in_valid = 1'b1; key_ready = 1'b1; out_ready = 1'b1;
    last_load = -1; n_loads = 0;
    for (cyc = 0; cyc < 45; cyc++) begin
      #1;
      if (state_load) begin
        if (last_load >= 0) begin
          chk("b2b_interval", cyc - last_load, NR + 1);
          chk("b2b_load_with_done", int'(out_valid && out_ready), 1);
        end
        last_load = cyc;
        n_loads++;
      end
      step();
    end
    chk("b2b_load_count", n_loads, 5);
    in_valid = 1'b0;
    repeat (15) step();

    // key_ready gating.
    in_valid = 1'b1; key_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("kr_no_load", int'(state_load), 0);
      chk("kr_idle_in_ready", int'(in_ready), 1);
      step();
    end
    key_ready = 1'b1; #1;
    chk("kr_accept_load", int'(state_load), 1);
    step(); in_valid = 1'b0;
    repeat (4) step();
    #1;
    chk("mid_key_sel", int'(key_sel), 5);

    // Reset mid-block.
    rst_n = 1'b0; #1;
    chk("mrst_state_en", int'(state_en), 0);
    chk("mrst_key_sel", int'(key_sel), 0);
    chk("mrst_mix_en", int'(mix_en), 0);
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_in_ready", int'(in_ready), 1);
    step(); step();
    rst_n = 1'b1; #1;
    chk("mrst_rel_in_ready", int'(in_ready), 1);
    n_ov = 0;
    for (int i = 0; i < 15; i++) begin
      step(); #1;
      if (out_valid) n_ov++;
    end
    chk("mrst_no_out_valid", n_ov, 0);

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
